// File: rtl/sm3_msg_feeder.sv
// Pads a byte-length message to SM3 blocks and streams 16-word blocks into top_sm3,
// respecting the core's hold handshake, then latches the resulting digest.
module sm3_msg_feeder #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len_bytes,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             sm3_valid_in,
    output logic             sm3_m,
    output logic [31:0]      sm3_message,
    input  logic             sm3_hold,
    input  logic [255:0]     sm3_hash,
    output logic             busy,
    output logic             done,
    output logic [255:0]     hash_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_WAIT_HI,
        S_WAIT_LO,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] nblk_q, nblk_d;
    logic [LEN_W-1:0] g_q, g_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [255:0]     hash_q, hash_d;

    logic [3:0]       w;
    logic [LEN_W-1:0] blk;
    logic [LEN_W-1:0] quarter;
    logic [1:0]       rem;
    logic [63:0]      bit_len;
    logic [LEN_W:0]   len_plus8;
    logic             last_blk;
    logic             needs_data;
    logic             feeding;
    logic             issue;
    logic [31:0]      word;

    assign w         = g_q[3:0];
    assign blk       = g_q >> 4;
    assign quarter   = {2'b00, len_q[LEN_W-1:2]};
    assign rem       = len_q[1:0];
    assign bit_len   = {{(64-LEN_W-3){1'b0}}, len_q, 3'b000};
    assign len_plus8 = {1'b0, len_bytes} + (LEN_W+1)'(8);
    assign last_blk  = (blk == nblk_q - LEN_W'(1));
    assign feeding   = (state_q == S_FEED);

    // Word g is message data before L/4, the partial-data/0x80 pad word at L/4,
    // the bit length in the last two slots of the final block, and zero elsewhere.
    always_comb begin
        needs_data = 1'b0;
        word       = 32'h0;
        if (g_q < quarter) begin
            needs_data = 1'b1;
            word       = in_data;
        end else if (g_q == quarter) begin
            case (rem)
                2'd0: word = 32'h8000_0000;
                2'd1: word = {in_data[31:24], 8'h80, 16'h0000};
                2'd2: word = {in_data[31:16], 8'h80, 8'h00};
                default: word = {in_data[31:8], 8'h80};
            endcase
            needs_data = (rem != 2'd0);
        end else if (last_blk && w == 4'd14) begin
            word = bit_len[63:32];
        end else if (last_blk && w == 4'd15) begin
            word = bit_len[31:0];
        end
    end

    assign issue        = feeding && !sm3_hold && (!needs_data || in_valid);
    assign in_ready     = feeding && needs_data && !sm3_hold;
    assign sm3_valid_in = issue;
    assign sm3_m        = issue && (w == 4'd0);
    assign sm3_message  = feeding ? word : 32'h0;
    assign busy         = busy_q;
    assign done         = done_q;
    assign hash_out     = hash_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        nblk_d  = nblk_q;
        g_d     = g_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hash_d  = hash_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len_bytes;
                    nblk_d  = LEN_W'(len_plus8 >> 6) + LEN_W'(1);
                    g_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                if (issue) begin
                    g_d = g_q + LEN_W'(1);
                    if (w == 4'd15) state_d = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (sm3_hold) state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                // g already points at the first word of the next block here.
                if (!sm3_hold) state_d = (blk == nblk_q) ? S_FINISH : S_FEED;
            end
            S_FINISH: begin
                hash_d  = sm3_hash;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            nblk_q  <= '0;
            g_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hash_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            nblk_q  <= nblk_d;
            g_q     <= g_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hash_q  <= hash_d;
        end
    end

endmodule

// File: tb/tb_sm3_msg_feeder.sv
// Directed bench: the bench plays both the CPU word source and the top_sm3 core,
// collecting issued words and comparing them against hand-padded blocks.
module tb_sm3_msg_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  len_bytes;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic         sm3_valid_in;
    logic         sm3_m;
    logic [31:0]  sm3_message;
    logic         sm3_hold;
    logic [255:0] sm3_hash;
    logic         busy;
    logic         done;
    logic [255:0] hash_out;

    logic         core_hold = 1'b0;
    logic         core_hold_nxt = 1'b0;
    logic         stall_hold = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] obs_w[$];
    logic        obs_m[$];
    int          blk_wcnt = 0;
    int          hold_cnt = 0;
    int          done_cnt = 0;
    int          ready_cnt = 0;
    bit          consumed_s = 1'b0;

    logic [31:0] feed_mem[0:15];
    int          feed_n = 0;
    int          feed_idx = 0;
    bit          gap_mode = 1'b0;
    bit          gap_phase = 1'b0;
    bit          stall_arm = 1'b0;
    int          stall_left = 0;
    logic [31:0] stall_word = 32'h0;
    logic [31:0] exp_w[0:31];
    int          base = 0;
    int          done0 = 0;
    int          ready0 = 0;

    assign sm3_hold = core_hold | stall_hold;

    always #5 clk = ~clk;

    sm3_msg_feeder #(.LEN_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len_bytes   (len_bytes),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .sm3_valid_in(sm3_valid_in),
        .sm3_m       (sm3_m),
        .sm3_message (sm3_message),
        .sm3_hold    (sm3_hold),
        .sm3_hash    (sm3_hash),
        .busy        (busy),
        .done        (done),
        .hash_out    (hash_out)
    );

    // Core model: after each 16th word the core raises hold for a few cycles.
    always @(negedge clk) begin
        if (rst) begin
            blk_wcnt   = 0;
            hold_cnt   = 0;
            consumed_s = 1'b0;
        end else begin
            consumed_s = in_valid && in_ready;
            if (in_ready) ready_cnt++;
            if (done) done_cnt++;
            if (sm3_valid_in) begin
                obs_w.push_back(sm3_message);
                obs_m.push_back(sm3_m);
                blk_wcnt = (blk_wcnt + 1) % 16;
                if (blk_wcnt == 0) hold_cnt = 4;
            end else if (hold_cnt > 0) begin
                hold_cnt--;
            end
        end
        core_hold_nxt = (hold_cnt > 0);
    end

    always @(posedge clk) begin
        #1;
        core_hold = core_hold_nxt;
    end

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #2;
        if (stall_left > 0) begin
            checkOutput("stall_valid", {255'h0, sm3_valid_in}, 256'h0);
            checkOutput("stall_msg", {224'h0, sm3_message}, {224'h0, stall_word});
            stall_left--;
            if (stall_left == 0) stall_hold = 1'b0;
        end else if (stall_arm && blk_wcnt == 5) begin
            stall_hold = 1'b1;
            stall_left = 3;
            stall_arm  = 1'b0;
        end
        if (consumed_s) feed_idx++;
        gap_phase = !gap_phase;
        if (feed_idx < feed_n) begin
            in_data  = feed_mem[feed_idx];
            in_valid = !(gap_mode && gap_phase);
        end else begin
            in_data  = 32'h0;
            in_valid = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] len, input int nfeed, input bit probe_start);
        feed_n   = nfeed;
        feed_idx = 0;
        stepCycle();
        start     = 1'b1;
        len_bytes = len;
        base      = obs_w.size();
        done0     = done_cnt;
        ready0    = ready_cnt;
        stepCycle();
        start = 1'b0;
        for (int i = 0; i < 600 && done_cnt == done0; i++) begin
            if (probe_start && i == 4) begin
                start     = 1'b1;
                len_bytes = 16'd100;
            end
            stepCycle();
            start = 1'b0;
        end
        checkOutput("done_seen", {255'h0, done_cnt != done0}, {255'h0, 1'b1});
        for (int i = 0; i < 3; i++) stepCycle();
    endtask

    task automatic checkWords(input string tag, input int nwords);
        checkOutput({tag, "_count"}, 256'(obs_w.size() - base), 256'(nwords));
        for (int i = 0; i < nwords && base + i < obs_w.size(); i++) begin
            checkOutput({tag, "_word"}, {224'h0, obs_w[base + i]}, {224'h0, exp_w[i]});
            checkOutput({tag, "_m"}, {255'h0, obs_m[base + i]}, {255'h0, (i % 16) == 0});
        end
        checkOutput({tag, "_done_once"}, 256'(done_cnt - done0), 256'd1);
        checkOutput({tag, "_busy"}, {255'h0, busy}, 256'h0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len_bytes = 16'h0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        sm3_hash  = 256'h0;
        for (int i = 0; i < 3; i++) stepCycle();
        rst = 1'b0;
        stepCycle();

        checkOutput("rst_busy", {255'h0, busy}, 256'h0);
        checkOutput("rst_done", {255'h0, done}, 256'h0);
        checkOutput("rst_hash", hash_out, 256'h0);
        checkOutput("rst_valid", {255'h0, sm3_valid_in}, 256'h0);
        checkOutput("rst_ready", {255'h0, in_ready}, 256'h0);
        checkOutput("rst_msg", {224'h0, sm3_message}, 256'h0);

        // Empty message: only the pad word and a zero length.
        sm3_hash = 256'h1ab21d8355cfa17f8e61194831e81a8f22bec8c728fefb747ed035eb5082aa2b;
        for (int i = 0; i < 32; i++) exp_w[i] = 32'h0;
        exp_w[0] = 32'h8000_0000;
        applyStimulus(16'd0, 0, 1'b0);
        checkWords("empty", 16);
        checkOutput("empty_ready_never", 256'(ready_cnt - ready0), 256'd0);
        checkOutput("empty_hash", hash_out, 256'h1ab21d8355cfa17f8e61194831e81a8f22bec8c728fefb747ed035eb5082aa2b);

        // "abc"
        sm3_hash = 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
        feed_mem[0] = 32'h6162_6300;
        for (int i = 0; i < 32; i++) exp_w[i] = 32'h0;
        exp_w[0]  = 32'h6162_6380;
        exp_w[15] = 32'h0000_0018;
        applyStimulus(16'd3, 1, 1'b0);
        checkWords("abc", 16);
        checkOutput("abc_hash", hash_out, 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0);

        // 56 bytes spill into a second block; core stalls mid-block at word 5.
        sm3_hash = {8{32'hA5A5_0001}};
        for (int i = 0; i < 32; i++) exp_w[i] = 32'h0;
        for (int i = 0; i < 14; i++) begin
            feed_mem[i] = 32'h1000_0000 + 32'(i * 17);
            exp_w[i]    = 32'h1000_0000 + 32'(i * 17);
        end
        exp_w[14] = 32'h8000_0000;
        exp_w[31] = 32'h0000_01C0;
        stall_word = 32'h1000_0055;
        stall_arm  = 1'b1;
        applyStimulus(16'd56, 14, 1'b0);
        checkWords("two_blk", 32);
        checkOutput("two_blk_stalled", {255'h0, stall_arm}, 256'h0);
        checkOutput("two_blk_hash", hash_out, {8{32'hA5A5_0001}});

        // Gapped source plus a start pulse while busy.
        sm3_hash = {8{32'h0BAD_F00D}};
        gap_mode = 1'b1;
        feed_mem[0] = 32'h1122_3344;
        feed_mem[1] = 32'h5566_AABB;
        for (int i = 0; i < 32; i++) exp_w[i] = 32'h0;
        exp_w[0]  = 32'h1122_3344;
        exp_w[1]  = 32'h5566_8000;
        exp_w[15] = 32'h0000_0030;
        applyStimulus(16'd6, 2, 1'b1);
        checkWords("gap", 16);
        checkOutput("gap_hash", hash_out, {8{32'h0BAD_F00D}});
        gap_mode = 1'b0;

        // Reset in the middle of a block aborts the message.
        for (int i = 0; i < 10; i++) feed_mem[i] = 32'hC0DE_0000 + 32'(i);
        feed_n   = 10;
        feed_idx = 0;
        stepCycle();
        start     = 1'b1;
        len_bytes = 16'd40;
        stepCycle();
        start = 1'b0;
        for (int i = 0; i < 100 && blk_wcnt != 8; i++) stepCycle();
        checkOutput("mid_reached_w8", 256'(blk_wcnt), 256'd8);
        rst = 1'b1;
        stepCycle();
        rst    = 1'b0;
        feed_n = 0;
        checkOutput("mid_rst_valid", {255'h0, sm3_valid_in}, 256'h0);
        checkOutput("mid_rst_ready", {255'h0, in_ready}, 256'h0);
        checkOutput("mid_rst_m", {255'h0, sm3_m}, 256'h0);
        checkOutput("mid_rst_msg", {224'h0, sm3_message}, 256'h0);
        checkOutput("mid_rst_busy", {255'h0, busy}, 256'h0);
        checkOutput("mid_rst_done", {255'h0, done}, 256'h0);
        checkOutput("mid_rst_hash", hash_out, 256'h0);

        sm3_hash = 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
        feed_mem[0] = 32'h6162_6300;
        for (int i = 0; i < 32; i++) exp_w[i] = 32'h0;
        exp_w[0]  = 32'h6162_6380;
        exp_w[15] = 32'h0000_0018;
        applyStimulus(16'd3, 1, 1'b0);
        checkWords("after_rst", 16);
        checkOutput("after_rst_hash", hash_out, 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
